// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: shared board constants and per-bit state type for the switch debouncer.
package hack_io_pkg;
    localparam int MOJO_CLK_HZ         = 50_000_000;
    localparam int DEBOUNCE_MS_DEFAULT = 10;
    localparam int SW_BANK_WIDTH       = 4;
    localparam int SW_TOTAL_WIDTH      = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;
    typedef enum logic {IDLE, PENDING} db_state_e;
    function automatic int debounce_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction
endpackage

// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch inputs and debounced outputs; sw_rise/sw_fall exist only with DEBOUNCE_EDGE_EN.
interface switch_debouncer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic             sw_change;
    logic             settled;
`ifdef DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    modport master (output sw_raw, input sw_stable, sw_change, settled, sw_rise, sw_fall);
    modport slave  (input sw_raw, output sw_stable, sw_change, settled, sw_rise, sw_fall);
`else
    modport master (output sw_raw, input sw_stable, sw_change, settled);
    modport slave  (input sw_raw, output sw_stable, sw_change, settled);
`endif
endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// debounce_bit: synchroniser, stability counter and accepted-level flop for one switch bit.
module debounce_bit
    import hack_io_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic upd_o,
    output logic pending_o
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   stable_q;
    logic                   upd_q;
    logic                   s;
    db_state_e              state;
    assign s         = sync_q[SYNC_STAGES-1];
    assign state     = (s != stable_q) ? PENDING : IDLE;
    assign pending_o = (state == PENDING);
    assign stable_o  = stable_q;
    assign upd_o     = upd_q;
    // A level is accepted on the cycle the count reaches its last value; any revert clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            upd_q    <= 1'b0;
            if (state == IDLE) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                stable_q <= s;
                cnt_q    <= '0;
                upd_q    <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit debounce of raw DIP switches with change/settled flags; optional edge pulses under DEBOUNCE_EDGE_EN.
module switch_debouncer
    import hack_io_pkg::*;
#(
    parameter int WIDTH         = SW_TOTAL_WIDTH,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT,
    parameter int STABLE_CYCLES = debounce_cycles(MOJO_CLK_HZ, DEBOUNCE_MS_DEFAULT)
) (
    input logic                clk,
    input logic                rst,
    switch_debouncer_if.slave  bus
);
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] pending;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            debounce_bit #(
                .SYNC_STAGES  (SYNC_STAGES),
                .STABLE_CYCLES(STABLE_CYCLES)
            ) u_bit (
                .clk      (clk),
                .rst      (rst),
                .raw_i    (bus.sw_raw[i]),
                .stable_o (stable[i]),
                .upd_o    (upd[i]),
                .pending_o(pending[i])
            );
        end
    endgenerate
    assign bus.sw_stable = stable;
    assign bus.sw_change = |upd;
    assign bus.settled   = ~|pending;
`ifdef DEBOUNCE_EDGE_EN
    assign bus.sw_rise   = upd & stable;
    assign bus.sw_fall   = upd & ~stable;
`endif
endmodule
